// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder reused over WIDTH clocks, LSB first,
// with valid/ready handshakes on the operand and result sides.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_data_in_a,
    input  logic [WIDTH-1:0] i_data_in_b,
    input  logic             i_data_in_c,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_data_out_sum,
    output logic             o_data_out_carry,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CntW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_carry_out;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_unused_sum_lsb;

    full_adder u_full_adder (
        .i_a     (r_a_sr[0]),
        .i_b     (r_b_sr[0]),
        .i_c     (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    assign w_last     = (r_bit_cnt == CntW'(WIDTH - 1));
    assign w_sum_next = {w_fa_sum, r_sum_sr[WIDTH-1:1]};
    // The LSB slot of the sum shifter is always shifted out before it is read.
    assign w_unused_sum_lsb = r_sum_sr[0];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_in_valid)  w_state_next = StRun;
            StRun:   if (w_last)      w_state_next = StDone;
            StDone:  if (i_out_ready) w_state_next = StIdle;
            default:                  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == StIdle);
        o_out_valid = (r_state == StDone);
        o_busy      = (r_state != StIdle);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_bit_cnt   <= '0;
            r_sum_out   <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a_sr    <= i_data_in_a;
                        r_b_sr    <= i_data_in_b;
                        r_carry   <= i_data_in_c;
                        r_bit_cnt <= '0;
                    end
                end
                StRun: begin
                    r_sum_sr  <= w_sum_next;
                    r_carry   <= w_fa_carry;
                    r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bit_cnt <= r_bit_cnt + CntW'(1);
                    if (w_last) begin
                        r_sum_out   <= w_sum_next;
                        r_carry_out <= w_fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data_out_sum   = r_sum_out;
    assign o_data_out_carry = r_carry_out;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16 against an
// arithmetic A+B+C reference with queued expected results.

module tb_serial_adder_ctrl;
    logic clk;
    logic rstn;

    logic [7:0]  a8, b8, sum8;
    logic        c8, iv8, ir8, cy8, ov8, or8, busy8;
    logic [15:0] a16, b16, sum16;
    logic        c16, iv16, ir16, cy16, ov16, or16, busy16;

    int checks;
    int errors;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .i_clock          (clk),
        .i_reset_n        (rstn),
        .i_data_in_a      (a8),
        .i_data_in_b      (b8),
        .i_data_in_c      (c8),
        .i_in_valid       (iv8),
        .o_in_ready       (ir8),
        .o_data_out_sum   (sum8),
        .o_data_out_carry (cy8),
        .o_out_valid      (ov8),
        .i_out_ready      (or8),
        .o_busy           (busy8)
    );

    serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
        .i_clock          (clk),
        .i_reset_n        (rstn),
        .i_data_in_a      (a16),
        .i_data_in_b      (b16),
        .i_data_in_c      (c16),
        .i_in_valid       (iv16),
        .o_in_ready       (ir16),
        .o_data_out_sum   (sum16),
        .o_data_out_carry (cy16),
        .o_out_valid      (ov16),
        .i_out_ready      (or16),
        .o_busy           (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one add on the 8-bit DUT and leaves it waiting in DONE with Out_ready low.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output int lat, output logic [7:0] s, output logic cy);
        a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        a8 = ~a; b8 = ~b; c8 = ~c;
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        s  = sum8;
        cy = cy8;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        checks++; if (ir8 !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b want 1", ir8); end
        checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", ov8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum8); end
        checks++; if (cy8 !== 1'b0)   begin errors++; $display("FAIL reset_carry got %b want 0", cy8); end
        checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0 || sum16 !== 16'h0)
            begin errors++; $display("FAIL reset_dut16 got ir=%b ov=%b sum=%h want 1 0 0000",
                                     ir16, ov16, sum16); end
    endtask

    task automatic test_basic();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vc [4];
        logic [8:0] exp;
        logic [7:0] s;
        logic       cy;
        int         lat;
        va[0] = 8'h5A; vb[0] = 8'h3C; vc[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0;
        va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1;
        va[3] = 8'h00; vb[3] = 8'h00; vc[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 9'(va[i]) + 9'(vb[i]) + 9'(vc[i]);
            run_op8(va[i], vb[i], vc[i], lat, s, cy);
            checks++; if (lat !== 8)      begin errors++; $display("FAIL basic_latency[%0d] got %0d want 8", i, lat); end
            checks++; if (s !== exp[7:0]) begin errors++; $display("FAIL basic_sum[%0d] got %h want %h", i, s, exp[7:0]); end
            checks++; if (cy !== exp[8])  begin errors++; $display("FAIL basic_carry[%0d] got %b want %b", i, cy, exp[8]); end
            checks++; if (ir8 !== 1'b0 || busy8 !== 1'b1)
                begin errors++; $display("FAIL basic_done_flags[%0d] got ir=%b busy=%b want 0 1", i, ir8, busy8); end
            or8 = 1'b1;
            tick();
            or8 = 1'b0;
            checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1)
                begin errors++; $display("FAIL basic_release[%0d] got ov=%b ir=%b want 0 1", i, ov8, ir8); end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp1, exp2;
        logic [7:0] s, xa, xb;
        logic       cy, xc;
        int         lat;
        xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom);
        exp1 = 9'(xa) + 9'(xb) + 9'(xc);
        run_op8(xa, xb, xc, lat, s, cy);
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            tick();
            checks++; if (ov8 !== 1'b1 || ir8 !== 1'b0)
                begin errors++; $display("FAIL bp_hold_flags[%0d] got ov=%b ir=%b want 1 0", i, ov8, ir8); end
            checks++; if ({cy8, sum8} !== exp1)
                begin errors++; $display("FAIL bp_hold_result[%0d] got %h want %h", i, {cy8, sum8}, exp1); end
        end
        xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom);
        exp2 = 9'(xa) + 9'(xb) + 9'(xc);
        a8 = xa; b8 = xb; c8 = xc; or8 = 1'b1;
        tick();
        or8 = 1'b0;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0)
            begin errors++; $display("FAIL bp_release got ir=%b ov=%b want 1 0", ir8, ov8); end
        tick();
        iv8 = 1'b0; a8 = ~xa; b8 = ~xb; c8 = ~xc;
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_new_latency got %0d want 8", lat); end
        checks++; if ({cy8, sum8} !== exp2)
            begin errors++; $display("FAIL bp_new_result got %h want %h", {cy8, sum8}, exp2); end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s;
        logic       cy;
        int         lat;
        int         seen;
        run_op8(8'hFF, 8'hFF, 1'b1, lat, s, cy);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick(); tick(); tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0)
            begin errors++; $display("FAIL abort_flags got ir=%b ov=%b busy=%b want 1 0 0", ir8, ov8, busy8); end
        checks++; if (sum8 !== 8'h00 || cy8 !== 1'b0)
            begin errors++; $display("FAIL abort_result got %h %b want 00 0", sum8, cy8); end
        or8 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov8) seen++;
        end
        or8 = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q[$];
        logic [8:0] exp;
        int         nacc, nres, cyc, last_acc;
        logic       acc;
        nacc = 0; nres = 0; cyc = 0; last_acc = -1;
        iv8 = 1'b1; or8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        while (nres < 10 && cyc < 300) begin
            acc = ir8 && iv8;
            if (acc) begin
                q.push_back(9'(a8) + 9'(b8) + 9'(c8));
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc !== 10)
                        begin errors++; $display("FAIL b2b_period got %0d want 10", cyc - last_acc); end
                end
                last_acc = cyc;
                nacc++;
            end
            if (ov8) begin
                exp = (q.size() > 0) ? q.pop_front() : 9'h1XX;
                checks++; if ({cy8, sum8} !== exp)
                    begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", nres, {cy8, sum8}, exp); end
                nres++;
            end
            tick();
            cyc++;
            if (acc) begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            end
            if (nacc >= 10) iv8 = 1'b0;
        end
        iv8 = 1'b0; or8 = 1'b0;
        checks++; if (nres !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", nres); end
    endtask

    task automatic test_random_regression();
        localparam int N = 1000;
        logic [8:0]  q8[$];
        logic [16:0] q16[$];
        logic [8:0]  e8;
        logic [16:0] e16;
        int acc8, acc16, res8, res16, cyc;
        acc8 = 0; acc16 = 0; res8 = 0; res16 = 0; cyc = 0;
        while (cyc < 80000 && !(acc8 >= N && acc16 >= N && q8.size() == 0 && q16.size() == 0)) begin
            iv8  = (acc8 < N)  ? 1'($urandom) : 1'b0;
            iv16 = (acc16 < N) ? 1'($urandom) : 1'b0;
            or8  = 1'($urandom);
            or16 = 1'($urandom);
            a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            if (ir8 && iv8) begin
                q8.push_back(9'(a8) + 9'(b8) + 9'(c8));
                acc8++;
            end
            if (ir16 && iv16) begin
                q16.push_back(17'(a16) + 17'(b16) + 17'(c16));
                acc16++;
            end
            if (ov8 && or8) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL rand8_extra got %h want none", {cy8, sum8});
                end else begin
                    e8 = q8.pop_front();
                    if ({cy8, sum8} !== e8)
                        begin errors++; $display("FAIL rand8_result[%0d] got %h want %h", res8, {cy8, sum8}, e8); end
                end
                res8++;
            end
            if (ov16 && or16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++; $display("FAIL rand16_extra got %h want none", {cy16, sum16});
                end else begin
                    e16 = q16.pop_front();
                    if ({cy16, sum16} !== e16)
                        begin errors++; $display("FAIL rand16_result[%0d] got %h want %h", res16, {cy16, sum16}, e16); end
                end
                res16++;
            end
            tick();
            cyc++;
        end
        iv8 = 1'b0; or8 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
        checks++; if (res8 !== N || acc8 !== N)
            begin errors++; $display("FAIL rand8_count got acc=%0d res=%0d want %0d", acc8, res8, N); end
        checks++; if (res16 !== N || acc16 !== N)
            begin errors++; $display("FAIL rand16_count got acc=%0d res=%0d want %0d", acc16, res16, N); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
        a16 = '0; b16 = '0; c16 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random_regression();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-multiplexes a single `full_adder` instance to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It accepts an operand pair through a valid/ready handshake, sequences WIDTH add steps through an internal carry register, and presents the registered sum and carry-out through a second valid/ready handshake. It trades latency for area and is the block the team uses wherever a wide ripple adder is too costly.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Reset_n  in  1  reset, synchronous, active-low; the clock and reset scheme is already decided as one clock with a synchronous active-low reset
- Data_in_A  in  WIDTH  operand A; sampled only on the input handshake
- Data_in_B  in  WIDTH  operand B; sampled only on the input handshake
- Data_in_C  in  1  carry-in; sampled only on the input handshake
- In_valid  in  1  operands present
- In_ready  out  1  controller can accept operands; high only in IDLE
- Data_out_Sum  out  WIDTH  registered sum (A+B+C) mod 2^WIDTH
- Data_out_Carry  out  1  registered carry-out, bit WIDTH of A+B+C
- Out_valid  out  1  result available; high only in DONE
- Out_ready  in  1  consumer takes the result
- Busy  out  1  high whenever the state is not IDLE

## Operation
- Exactly one `full_adder` instance is used. Its inputs are a_sr[0], b_sr[0], and carry_reg. Every bit of the sum is produced by this instance.
- State machine: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - In_ready=1.
  - When In_valid=1 at an edge: load a_sr<=Data_in_A, b_sr<=Data_in_B, carry_reg<=Data_in_C, bit_cnt<=0, and go to RUN.
- RUN, on each edge:
  - sum_sr<={fa_sum, sum_sr[WIDTH-1:1]}, which shifts the new bit in at the MSB and moves earlier bits toward the LSB.
  - carry_reg<=fa_carry.
  - a_sr and b_sr shift right by 1.
  - bit_cnt increments.
- RUN exit: on the edge where bit_cnt==WIDTH-1:
  - Data_out_Sum<=final sum_sr value, including the current bit.
  - Data_out_Carry<=fa_carry.
  - Go to DONE.
- DONE:
  - Out_valid=1.
  - Data_out_Sum and Data_out_Carry are held stable.
  - When Out_ready=1 at an edge, go to IDLE.
- Ignored inputs:
  - In_valid is ignored in RUN and DONE; no operands are queued.
  - Out_ready is ignored in IDLE and RUN.
- After leaving DONE, Data_out_Sum and Data_out_Carry keep the last result until the next RUN exit overwrites them.
- bit_cnt width is clog2(WIDTH). It never wraps inside RUN because it is reloaded on accept.
- Reset (Reset_n=0 at an edge) has priority over every transition:
  - State goes to IDLE.
  - All shift registers, carry_reg, bit_cnt, Data_out_Sum, and Data_out_Carry are cleared to 0.
- Reset in the middle of RUN or DONE abandons the operation silently; no Out_valid is produced for it.

## Timing
- Reset values: In_ready=1, Out_valid=0, Busy=0, Data_out_Sum=0, Data_out_Carry=0.
- Input handshake at edge E0. RUN lasts exactly WIDTH cycles. DONE is entered at edge E(WIDTH), so Out_valid is high in the cycle after E(WIDTH).
- Latency from accept to Out_valid is WIDTH clocks.
- In_ready is low in the cycle after E0 and stays low through DONE.
- Output handshake at edge Ed: Out_valid=0 and In_ready=1 in the following cycle.
- Minimum period between accepts is WIDTH+2 cycles: WIDTH RUN cycles, one DONE cycle, and the IDLE accept cycle.
- Holding In_valid=1 continuously yields back-to-back operations at this period.
- All outputs come directly from registers or the state decode; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, C=0 → Out_valid rises exactly 8 clocks after accept; Sum=0x96, Carry=0.
- A=0xFF, B=0x01, C=0 → Sum=0x00, Carry=1. A=0xFF, B=0xFF, C=1 → Sum=0xFF, Carry=1. A=0, B=0, C=1 → Sum=0x01, Carry=0.
- Backpressure: hold Out_ready=0 for 5 cycles in DONE while driving In_valid=1 with new operands → Sum and Carry stay stable, In_ready=0, and the new operands are not captured. With Out_ready=1: IDLE next cycle, then the new operands are accepted.
- Reset_n=0 for one edge at RUN cycle 4 of A=0xAA, B=0x55 → next cycle state is IDLE, In_ready=1, Out_valid=0, Sum=0, Carry=0, and no Out_valid appears for the aborted add.
- Throughput: In_valid and Out_ready held at 1 for 10 operations → one accept every 10 cycles at WIDTH=8, and every result is correct.
- Random regression of 1000 operations at WIDTH=8 and WIDTH=16 with random In_valid and Out_ready stalls → every result equals A+B+C, split into Sum and Carry, and no result is dropped or duplicated.
